// File: rtl/gpmc_async_slave_if.sv
// gpmc_async_slave_if: GPMC pads, NCS4 TX/RX streams and NCS6 register port
interface gpmc_async_slave_if;
  logic [9:0]  EM_A;
  logic [15:0] EM_D_in;
  logic [15:0] EM_D_out;
  logic        EM_D_oe;
  logic        EM_NCS4;
  logic        EM_NCS6;
  logic        EM_NWE;
  logic        EM_NOE;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [9:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic [15:0] reg_rdata;
  logic [7:0]  tx_overrun;
  logic [7:0]  rx_underrun;
  modport slave (
    input  EM_A, EM_D_in, EM_NCS4, EM_NCS6, EM_NWE, EM_NOE, tx_ready, rx_data, rx_valid, reg_rdata,
    output EM_D_out, EM_D_oe, tx_data, tx_valid, rx_ready, reg_addr, reg_wdata, reg_we, tx_overrun, rx_underrun
  );
  modport master (
    output EM_A, EM_D_in, EM_NCS4, EM_NCS6, EM_NWE, EM_NOE, tx_ready, rx_data, rx_valid, reg_rdata,
    input  EM_D_out, EM_D_oe, tx_data, tx_valid, rx_ready, reg_addr, reg_wdata, reg_we, tx_overrun, rx_underrun
  );
endinterface

// File: rtl/gpmc_async_slave.sv
// gpmc_async_slave: GPMC async bus slave turning bus cycles into single-cycle stream and register events
module gpmc_async_slave #(
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic reset_n,
  gpmc_async_slave_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] cs4_sr, cs6_sr, nwe_sr, noe_sr, flushed;
  logic cs4, cs6, nwe, noe, armed, sel6, sel6_n, pf_v, wr_end, rd_end, commit, rd4_end;
  logic [15:0] pf, d_q;
  logic [9:0] a_q;
  assign cs4 = cs4_sr[SYNC_STAGES-1];
  assign cs6 = cs6_sr[SYNC_STAGES-1];
  assign nwe = nwe_sr[SYNC_STAGES-1];
  assign noe = noe_sr[SYNC_STAGES-1];
  assign wr_end = nwe | (cs4 & cs6);
  assign rd_end = noe | (cs4 & cs6);
  assign commit = (state == WR) & wr_end;
  assign rd4_end = (state == RD) & rd_end & ~sel6;
  assign bus.rx_ready = reset_n & ~pf_v;
  // armed only once the synchronizers hold real pad samples showing both CS high
  always_comb begin
    state_n = state;
    sel6_n = sel6;
    case (state)
      IDLE: if (armed && !(cs4 && cs6) && !(nwe && noe)) begin
        state_n = nwe ? RD : WR;
        sel6_n = cs4;
      end
      WR: state_n = wr_end ? IDLE : WR;
      RD: state_n = rd_end ? IDLE : RD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {cs4_sr, cs6_sr, nwe_sr, noe_sr} <= '1;
      flushed <= '0;
      state <= IDLE;
      sel6 <= 1'b0;
      armed <= 1'b0;
      a_q <= '0;
      d_q <= '0;
      pf <= '0;
      pf_v <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.tx_data <= '0;
      bus.tx_overrun <= '0;
      bus.rx_underrun <= '0;
      bus.reg_we <= 1'b0;
      bus.reg_addr <= '0;
      bus.reg_wdata <= '0;
      bus.EM_D_out <= '0;
      bus.EM_D_oe <= 1'b0;
    end else begin
      cs4_sr <= {cs4_sr[SYNC_STAGES-2:0], bus.EM_NCS4};
      cs6_sr <= {cs6_sr[SYNC_STAGES-2:0], bus.EM_NCS6};
      nwe_sr <= {nwe_sr[SYNC_STAGES-2:0], bus.EM_NWE};
      noe_sr <= {noe_sr[SYNC_STAGES-2:0], bus.EM_NOE};
      flushed <= {flushed[SYNC_STAGES-2:0], 1'b1};
      state <= state_n;
      sel6 <= sel6_n;
      armed <= armed | (flushed[SYNC_STAGES-1] & cs4 & cs6);
      if (!nwe || !noe) begin
        a_q <= bus.EM_A;
        d_q <= bus.EM_D_in;
      end
      bus.tx_valid <= commit & ~sel6 & bus.tx_ready;
      if (commit && !sel6 && bus.tx_ready) bus.tx_data <= d_q;
      if (commit && !sel6 && !bus.tx_ready && bus.tx_overrun != 8'hff) bus.tx_overrun <= bus.tx_overrun + 8'd1;
      bus.reg_we <= commit & sel6;
      if (commit && sel6) begin
        bus.reg_addr <= a_q;
        bus.reg_wdata <= d_q;
      end else if (state == IDLE && state_n == RD && sel6_n) bus.reg_addr <= bus.EM_A;
      if (!pf_v && bus.rx_valid) pf <= bus.rx_data;
      pf_v <= pf_v ? ~rd4_end : bus.rx_valid;
      if (rd4_end && !pf_v && bus.rx_underrun != 8'hff) bus.rx_underrun <= bus.rx_underrun + 8'd1;
      bus.EM_D_oe <= state_n == RD;
      bus.EM_D_out <= (state_n != RD) ? 16'h0 : !sel6_n ? (pf_v ? pf : 16'h0) : (state == RD) ? bus.reg_rdata : 16'h0;
    end
  end
endmodule
